// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master (CPU / external) arbiter in front of a single-port
// synchronous data memory. Round-robin on ties, lock-based ownership,
// per-requester starvation forcing and a two-deep read-return tracker.
// Build option: define DMEM_ARB_EXT_PRIO_EN to give EXT fixed priority on
// idle-state ties (starvation forcing of the CPU still applies).
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_EXT = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_t            state_q, state_d;
    logic              lastExt_q, lastExt_d;
    logic [3:0]        cpuCnt_q, cpuCnt_d;
    logic [3:0]        extCnt_q, extCnt_d;
    logic              cpuForce, extForce, tieCpuWins;
    logic              cpuGnt, extGnt;
    logic              winWe;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winWdata;
    logic              memEn_q, memWe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memWdata_q;
    logic [1:0]        rdValid_q;
    logic [1:0]        rdExt_q;

    // A requester that has waited MAX_WAIT cycles must be served now.
    assign cpuForce = cpu_req && (cpuCnt_q >= MAX_CNT);
    assign extForce = ext_req && (extCnt_q >= MAX_CNT);

`ifdef DMEM_ARB_EXT_PRIO_EN
    assign tieCpuWins = 1'b0;
`else
    assign tieCpuWins = lastExt_q;
`endif

    // Grant selection and ownership next-state; forcing beats ownership.
    always_comb begin
        cpuGnt  = 1'b0;
        extGnt  = 1'b0;
        state_d = state_q;
        if (cpuForce) begin
            cpuGnt  = 1'b1;
            state_d = IDLE;
        end else if (extForce) begin
            extGnt  = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                OWN_CPU: begin
                    cpuGnt = cpu_req;
                    if (!cpu_lock) state_d = IDLE;
                end
                OWN_EXT: begin
                    extGnt = ext_req;
                    if (!ext_lock) state_d = IDLE;
                end
                default: begin
                    if (cpu_req && ext_req) begin
                        cpuGnt = tieCpuWins;
                        extGnt = !tieCpuWins;
                    end else begin
                        cpuGnt = cpu_req;
                        extGnt = ext_req;
                    end
                    if (cpuGnt && cpu_lock) begin
                        state_d = OWN_CPU;
                    end else if (extGnt && ext_lock) begin
                        state_d = OWN_EXT;
                    end
                end
            endcase
        end
    end

    // Winner's access fields, last-grant pointer and saturating wait counters.
    always_comb begin
        winWe     = extGnt ? ext_we    : cpu_we;
        winAddr   = extGnt ? ext_addr  : cpu_addr;
        winWdata  = extGnt ? ext_wdata : cpu_wdata;
        lastExt_d = lastExt_q;
        if (extGnt) begin
            lastExt_d = 1'b1;
        end else if (cpuGnt) begin
            lastExt_d = 1'b0;
        end
        cpuCnt_d = 4'd0;
        if (cpu_req && !cpuGnt) begin
            cpuCnt_d = (cpuCnt_q >= MAX_CNT) ? cpuCnt_q : cpuCnt_q + 4'd1;
        end
        extCnt_d = 4'd0;
        if (ext_req && !extGnt) begin
            extCnt_d = (extCnt_q >= MAX_CNT) ? extCnt_q : extCnt_q + 4'd1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lastExt_q <= 1'b1;
            cpuCnt_q  <= 4'd0;
            extCnt_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            lastExt_q <= lastExt_d;
            cpuCnt_q  <= cpuCnt_d;
            extCnt_q  <= extCnt_d;
        end
    end

    // Registered memory port; address and data hold when nothing is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else if (cpuGnt || extGnt) begin
            memEn_q    <= 1'b1;
            memWe_q    <= winWe;
            memAddr_q  <= winAddr;
            memWdata_q <= winWdata;
        end else begin
            memEn_q <= 1'b0;
            memWe_q <= 1'b0;
        end
    end

    // Two-stage read tracker: stage 0 = port register, stage 1 = memory data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdValid_q <= 2'b00;
            rdExt_q   <= 2'b00;
        end else begin
            rdValid_q <= {rdValid_q[0], (cpuGnt || extGnt) && !winWe};
            rdExt_q   <= {rdExt_q[0], extGnt};
        end
    end

    assign cpu_gnt    = cpuGnt;
    assign ext_gnt    = extGnt;
    assign mem_en     = memEn_q;
    assign mem_we     = memWe_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign cpu_rvalid = rdValid_q[1] && !rdExt_q[1];
    assign ext_rvalid = rdValid_q[1] && rdExt_q[1];
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run, all compared against a cycle-level behavioural model of the
// arbiter (ownership, wait counts, last winner, expected read returns).
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 4;

    typedef struct {
        logic          cReq, cWe, cLock;
        logic [AW-1:0] cAddr;
        logic [DW-1:0] cWdata;
        logic          eReq, eWe, eLock;
        logic [AW-1:0] eAddr;
        logic [DW-1:0] eWdata;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  expC, expE;
    } vec_t;

    typedef struct {
        int            due;
        int            owner;
        logic [DW-1:0] data;
    } rd_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] rdata;

    logic [DW-1:0] memArr [64] = '{default: '0};

    int            nChecks = 0;
    int            nFails  = 0;
    int            cycleNo;
    int            mOwner, mCntC, mCntE, mLast;
    logic          mMemEn, mMemWe;
    logic [AW-1:0] mMemAddr;
    logic [DW-1:0] mMemWdata;
    logic [DW-1:0] shadow [64] = '{default: '0};
    rd_t           pending[$];
    vec_t          vecs[10];

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rdata(rdata)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Synchronous single-port memory behind the arbiter.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) memArr[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= memArr[mem_addr[7:2]];
        end
    end

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s (cycle %0d): actual %b required %b", name, cycleNo, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s (cycle %0d): actual %h required %h", name, cycleNo, act, exp);
        end
    endtask

    function automatic stim_t mkStim(input logic cr, input logic cw, input logic cl,
                                     input logic er, input logic ew, input logic el,
                                     input int idx);
        stim_t s;
        s.cReq = cr; s.cWe = cw; s.cLock = cl;
        s.eReq = er; s.eWe = ew; s.eLock = el;
        s.cAddr  = 32'h0200_0000 + 32'(idx) * 32'd8;
        s.eAddr  = 32'h0200_0004 + 32'(idx) * 32'd8;
        s.cWdata = 32'h5 + 32'(idx) * 32'h10;
        s.eWdata = 32'h9 + 32'(idx) * 32'h10;
        return s;
    endfunction

    function automatic stim_t mkRand();
        stim_t s;
        s.cReq   = ($urandom_range(0, 99) < 60);
        s.cWe    = ($urandom_range(0, 99) < 50);
        s.cLock  = ($urandom_range(0, 99) < 20);
        s.eReq   = ($urandom_range(0, 99) < 60);
        s.eWe    = ($urandom_range(0, 99) < 50);
        s.eLock  = ($urandom_range(0, 99) < 20);
        s.cAddr  = 32'h0200_0000 + 32'($urandom_range(0, 15)) * 32'd4;
        s.eAddr  = 32'h0200_0000 + 32'($urandom_range(0, 15)) * 32'd4;
        s.cWdata = $urandom;
        s.eWdata = $urandom;
        return s;
    endfunction

    // Winner by rule: starved requester first (CPU before EXT), then owner,
    // then idle arbitration. 0 = nobody, 1 = CPU, 2 = EXT.
    function automatic int modelWinner(input stim_t s);
        if (s.cReq && mCntC >= MW) return 1;
        if (s.eReq && mCntE >= MW) return 2;
        if (mOwner == 1) return s.cReq ? 1 : 0;
        if (mOwner == 2) return s.eReq ? 2 : 0;
        if (s.cReq && s.eReq) begin
`ifdef DMEM_ARB_EXT_PRIO_EN
            return 2;
`else
            return (mLast == 2) ? 1 : 2;
`endif
        end
        if (s.cReq) return 1;
        if (s.eReq) return 2;
        return 0;
    endfunction

    task automatic checkOutput(input stim_t s, output int win);
        logic          expRvC, expRvE;
        logic [DW-1:0] expData;
        win = modelWinner(s);
        checkBit("cpu_gnt", cpu_gnt, win == 1);
        checkBit("ext_gnt", ext_gnt, win == 2);
        checkBit("mem_en", mem_en, mMemEn);
        checkBit("mem_we", mem_we, mMemWe);
        checkWord("mem_addr", mem_addr, mMemAddr);
        checkWord("mem_wdata", mem_wdata, mMemWdata);
        expRvC  = 1'b0;
        expRvE  = 1'b0;
        expData = '0;
        if (pending.size() > 0 && pending[0].due == cycleNo) begin
            if (pending[0].owner == 1) expRvC = 1'b1;
            else                       expRvE = 1'b1;
            expData = pending[0].data;
            void'(pending.pop_front());
        end
        checkBit("cpu_rvalid", cpu_rvalid, expRvC);
        checkBit("ext_rvalid", ext_rvalid, expRvE);
        if (expRvC || expRvE) checkWord("rdata", rdata, expData);
    endtask

    task automatic modelAdvance(input stim_t s, input int win);
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        bit            forced;
        we = (win == 1) ? s.cWe    : s.eWe;
        ad = (win == 1) ? s.cAddr  : s.eAddr;
        wd = (win == 1) ? s.cWdata : s.eWdata;
        forced = (s.cReq && mCntC >= MW) || (s.eReq && mCntE >= MW);
        if (win != 0) begin
            mMemEn = 1'b1; mMemWe = we; mMemAddr = ad; mMemWdata = wd;
            if (we) shadow[ad[7:2]] = wd;
            else    pending.push_back('{due: cycleNo + 2, owner: win, data: shadow[ad[7:2]]});
            mLast = win;
        end else begin
            mMemEn = 1'b0; mMemWe = 1'b0;
        end
        mCntC = (s.cReq && win != 1) ? mCntC + 1 : 0;
        mCntE = (s.eReq && win != 2) ? mCntE + 1 : 0;
        if (forced)                         mOwner = 0;
        else if (mOwner == 0 && win == 1 && s.cLock) mOwner = 1;
        else if (mOwner == 0 && win == 2 && s.eLock) mOwner = 2;
        else if (mOwner == 1 && !s.cLock)   mOwner = 0;
        else if (mOwner == 2 && !s.eLock)   mOwner = 0;
        cycleNo++;
    endtask

    task automatic applyStimulus(input stim_t s, output int win);
        @(negedge clk);
        cpu_req = s.cReq; cpu_we = s.cWe; cpu_lock = s.cLock;
        cpu_addr = s.cAddr; cpu_wdata = s.cWdata;
        ext_req = s.eReq; ext_we = s.eWe; ext_lock = s.eLock;
        ext_addr = s.eAddr; ext_wdata = s.eWdata;
        #1;
        checkOutput(s, win);
        modelAdvance(s, win);
    endtask

    task automatic doReset();
        @(negedge clk);
        cpu_req = 1'b0; ext_req = 1'b0;
        reset_n = 1'b0;
        #1;
        checkBit("reset mem_en", mem_en, 1'b0);
        checkBit("reset mem_we", mem_we, 1'b0);
        checkWord("reset mem_addr", mem_addr, 32'h0);
        checkWord("reset mem_wdata", mem_wdata, 32'h0);
        checkBit("reset cpu_rvalid", cpu_rvalid, 1'b0);
        checkBit("reset ext_rvalid", ext_rvalid, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        mOwner = 0; mCntC = 0; mCntE = 0; mLast = 2;
        mMemEn = 1'b0; mMemWe = 1'b0; mMemAddr = '0; mMemWdata = '0;
        pending.delete();
        cycleNo = 0;
    endtask

    // Main test sequence.
    initial begin
        int    win;
        int    waited;
        bit    got;
        stim_t s;

        reset_n = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = '0; ext_wdata = '0;
        cycleNo = 0;

        vecs[0] = '{mkStim(1, 1, 0, 1, 1, 0, 0), 1'b1, 1'b0};
        vecs[1] = '{mkStim(1, 1, 0, 1, 1, 0, 0), 1'b0, 1'b1};
        vecs[2] = '{mkStim(1, 0, 0, 0, 0, 0, 2), 1'b1, 1'b0};
        vecs[3] = '{mkStim(0, 0, 0, 1, 0, 1, 3), 1'b0, 1'b1};
        vecs[4] = '{mkStim(1, 0, 0, 1, 0, 1, 4), 1'b0, 1'b1};
        vecs[5] = '{mkStim(1, 0, 0, 1, 0, 1, 5), 1'b0, 1'b1};
        vecs[6] = '{mkStim(1, 0, 0, 1, 0, 0, 6), 1'b0, 1'b1};
        vecs[7] = '{mkStim(1, 1, 0, 1, 1, 0, 7), 1'b1, 1'b0};
        vecs[8] = '{mkStim(0, 0, 0, 0, 0, 0, 8), 1'b0, 1'b0};
        vecs[9] = '{mkStim(0, 1, 0, 1, 1, 0, 9), 1'b0, 1'b1};
`ifdef DMEM_ARB_EXT_PRIO_EN
        vecs[0].expC = 1'b0; vecs[0].expE = 1'b1;
        vecs[7].expC = 1'b0; vecs[7].expE = 1'b1;
`endif

        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].s, win);
            checkBit($sformatf("vec%0d cpu_gnt", i), cpu_gnt, vecs[i].expC);
            checkBit($sformatf("vec%0d ext_gnt", i), ext_gnt, vecs[i].expE);
`ifndef DMEM_ARB_EXT_PRIO_EN
            if (i == 1) checkWord("first write data", mem_wdata, 32'h5);
            if (i == 2) checkWord("second write data", mem_wdata, 32'h9);
            if (i == 2) checkWord("second write addr", mem_addr, 32'h0200_0004);
`endif
        end

        // Locked EXT keeps CPU waiting until its counter forces a grant.
        doReset();
        applyStimulus(mkStim(0, 0, 0, 1, 0, 1, 1), win);
        waited = 0;
        got    = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            applyStimulus(mkStim(1, 0, 0, 1, 0, 1, 2), win);
            if (cpu_gnt) got = 1'b1;
            else         waited++;
        end
        checkBit("forced cpu grant seen", got, 1'b1);
        checkWord("denied cycles before force", 32'(waited), 32'(MW));
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 3), win);
        checkBit("idle after force", cpu_gnt, 1'b1);

        // EXT write immediately followed by CPU read of the same word.
        doReset();
        s = mkStim(0, 0, 0, 1, 1, 0, 0);
        s.eAddr = 32'h0200_0000; s.eWdata = 32'hA5;
        applyStimulus(s, win);
        s = mkStim(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(s, win);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0), win);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0), win);
        checkBit("raw cpu_rvalid", cpu_rvalid, 1'b1);
        checkWord("raw rdata", rdata, 32'hA5);

        // Reset between a CPU read grant and its return discards the read.
        doReset();
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 4), win);
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0), win);
            checkBit("no rvalid after reset", cpu_rvalid, 1'b0);
        end

        // Randomized traffic with a reset in the middle.
        doReset();
        for (int k = 0; k < 600; k++) begin
            if (k == 300) doReset();
            applyStimulus(mkRand(), win);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width of all data buses.
REQ-002 Parameter ADDR_W, default 32, byte address width of all address buses.
REQ-003 Parameter MAX_WAIT, default 4, consecutive denied cycles before a requester is force-granted (range 1..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cpu_req, cpu_we, cpu_lock  input  1 each  CPU access request, write enable, hold-ownership.
REQ-007 cpu_addr  input  ADDR_W; cpu_wdata  input  DATA_W  CPU access address and write data.
REQ-008 cpu_gnt  output  1  CPU access issued to memory this cycle; cpu_rvalid  output  1  CPU read data valid.
REQ-009 ext_req, ext_we, ext_lock  input  1 each  external driver (preload/capture) request, write, hold.
REQ-010 ext_addr  input  ADDR_W; ext_wdata  input  DATA_W  external access address and write data.
REQ-011 ext_gnt  output  1; ext_rvalid  output  1  same meaning as the CPU pair.
REQ-012 mem_en, mem_we  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory port, registered.
REQ-013 mem_rdata  input  DATA_W  synchronous memory read data, valid the cycle after mem_en with mem_we=0.
REQ-014 rdata  output  DATA_W  mem_rdata passed through combinationally; qualified by cpu_rvalid/ext_rvalid.

Function
REQ-015 FSM states IDLE, OWN_CPU, OWN_EXT; OWN_x entered only when the granted requester has its lock input high.
REQ-016 IDLE, one requester: that requester is granted the same cycle (gnt combinational from req and state).
REQ-017 IDLE, both requesting: round-robin; the requester not granted most recently wins; last-grant pointer resets to EXT so CPU wins first tie.
REQ-018 Grant issues one access: on the following edge mem_en=1 and mem_we/mem_addr/mem_wdata capture the winner's we/addr/wdata.
REQ-019 No gnt in a cycle: mem_en=0 and mem_we=0 on the following edge; mem_addr/mem_wdata hold.
REQ-020 Read latency: x_rvalid=1 exactly two edges after a gnt with we=0 (one edge for the register, one for memory); writes never raise rvalid.
REQ-021 Granted requester with lock=1 moves the FSM to OWN_x; in OWN_x only x is granted, every cycle x_req is high.
REQ-022 OWN_x returns to IDLE on the first edge where x_lock=0; that cycle is still arbitrated as OWN_x.
REQ-023 Starvation counter per requester, 4 bits: increments each cycle the requester's req=1 and gnt=0, clears on gnt or req=0.
REQ-024 Counter reaching MAX_WAIT forces grant to that requester next cycle, overriding round-robin and OWN state; FSM returns to IDLE.
REQ-025 Both counters at MAX_WAIT in the same cycle: CPU is force-granted; EXT keeps its count.
REQ-026 Never both gnt outputs high in one cycle; gnt never high without the matching req.
REQ-027 Requester dropping req while gnt would be high: no access issued, pointer unchanged.
REQ-028 Outstanding read tracking: 2-entry shift register of {valid, owner}; a new grant may issue every cycle (back-to-back, including read after write to same address).

Reset
REQ-029 reset_n low: asynchronously FSM=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, both rvalid=0, both counters=0, pointer=EXT.
REQ-030 Reset mid-operation discards outstanding reads: no rvalid after deassertion for accesses issued before it.
REQ-031 First grant possible in the first cycle after reset_n deasserts.

Configuration
REQ-032 Macro DMEM_ARB_EXT_PRIO_EN defined: in IDLE, EXT wins all ties (fixed priority); starvation forcing (REQ-023..025) still applies to CPU.
REQ-033 Macro undefined: round-robin per REQ-017; port list identical in both builds.

Verification
REQ-034 Both req from reset, cpu_we=1 addr 0x02000000 data 0x5, ext_we=1 addr 0x02000004 data 0x9 -> cpu_gnt cycle 0, ext_gnt cycle 1; mem writes 0x5 then 0x9 in that order.
REQ-035 ext_lock=1, ext issues 3 reads while cpu_req=1, MAX_WAIT=4 -> 3 ext_gnt, ext_rvalid 2 cycles after each; cpu_gnt on cycle 3 after lock release.
REQ-036 ext_lock held, ext_req continuous, cpu_req=1 -> cpu_gnt forced on cycle 4 (count reaches 4), FSM in IDLE afterward.
REQ-037 Write 0xA5 to 0x02000000 by EXT then CPU read same address next cycle -> cpu_rvalid with rdata=0xA5.
REQ-038 Issue CPU read, assert reset_n low for 1 cycle before rvalid -> cpu_rvalid never asserts; all outputs at reset values.
REQ-039 DMEM_ARB_EXT_PRIO_EN build, both req continuous, no locks -> ext_gnt cycles 0..3, cpu_gnt cycle 4 by starvation forcing, ext_gnt resumes cycle 5.
